// File: rtl/reg_file_param_if.sv
// Decode/execute side bundle for reg_file_param: read/write/clear requests and results.
// The master drives requests; the slave (register file) returns operands and pulses.
interface reg_file_param_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
);
   logic              rd1_en;
   logic [ADDR_W-1:0] rd1_addr;
   logic              rd2_en;
   logic [ADDR_W-1:0] rd2_addr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr_req;
   logic              ready;
   logic [DATA_W-1:0] rd1_data;
   logic              rd1_valid;
   logic [DATA_W-1:0] rd2_data;
   logic              rd2_valid;
   logic              wr_ack;
   logic              clr_done;

   modport master (
      output rd1_en, rd1_addr, rd2_en, rd2_addr, wr_en, wr_addr, wr_data, clr_req,
      input  ready, rd1_data, rd1_valid, rd2_data, rd2_valid, wr_ack, clr_done
   );

   modport slave (
      input  rd1_en, rd1_addr, rd2_en, rd2_addr, wr_en, wr_addr, wr_data, clr_req,
      output ready, rd1_data, rd1_valid, rd2_data, rd2_valid, wr_ack, clr_done
   );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised 2R/1W register file with registered reads, write-first bypass,
// optional hardwired-zero register 0 and a sequenced full-array clear.
module reg_file_param #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                 clk,
   input  logic                 rstn,
   reg_file_param_if.slave      bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd1_data_q, rd1_data_d;
   logic [DATA_W-1:0] rd2_data_q, rd2_data_d;
   logic              rd1_valid_q, rd1_valid_d;
   logic              rd2_valid_q, rd2_valid_d;
   logic              wr_ack_q, wr_ack_d;
   logic              clr_done_q, clr_done_d;

   // Zero register wins over bypass, so a write to r0 never leaks through.
   function automatic logic [DATA_W-1:0] read_value(
      input logic [ADDR_W-1:0] addr,
      input logic              wen,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata,
      input logic [DATA_W-1:0] stored
   );
      if (ZERO_REG && (addr == '0)) begin
         return '0;
      end else if (wen && (waddr == addr)) begin
         return wdata;
      end else begin
         return stored;
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mem_d       = mem_q;
      rd1_data_d  = rd1_data_q;
      rd2_data_d  = rd2_data_q;
      rd1_valid_d = 1'b0;
      rd2_valid_d = 1'b0;
      wr_ack_d    = 1'b0;
      clr_done_d  = 1'b0;

      if (state_q == ST_IDLE) begin
         if (bus.rd1_en) begin
            rd1_data_d  = read_value(bus.rd1_addr, bus.wr_en, bus.wr_addr, bus.wr_data,
                                     mem_q[bus.rd1_addr]);
            rd1_valid_d = 1'b1;
         end
         if (bus.rd2_en) begin
            rd2_data_d  = read_value(bus.rd2_addr, bus.wr_en, bus.wr_addr, bus.wr_data,
                                     mem_q[bus.rd2_addr]);
            rd2_valid_d = 1'b1;
         end
         if (bus.wr_en) begin
            wr_ack_d = 1'b1;
            if (!(ZERO_REG && (bus.wr_addr == '0))) begin
               mem_d[bus.wr_addr] = bus.wr_data;
            end
         end
         if (bus.clr_req) begin
            state_d = ST_CLEAR;
            idx_d   = '0;
         end
      end else begin
         mem_d[idx_q] = '0;
         if (&idx_q) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            clr_done_d = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         rd1_data_q  <= '0;
         rd2_data_q  <= '0;
         rd1_valid_q <= 1'b0;
         rd2_valid_q <= 1'b0;
         wr_ack_q    <= 1'b0;
         clr_done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rd1_data_q  <= rd1_data_d;
         rd2_data_q  <= rd2_data_d;
         rd1_valid_q <= rd1_valid_d;
         rd2_valid_q <= rd2_valid_d;
         wr_ack_q    <= wr_ack_d;
         clr_done_q  <= clr_done_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign bus.ready     = (state_q == ST_IDLE);
   assign bus.rd1_data  = rd1_data_q;
   assign bus.rd1_valid = rd1_valid_q;
   assign bus.rd2_data  = rd2_data_q;
   assign bus.rd2_valid = rd2_valid_q;
   assign bus.wr_ack    = wr_ack_q;
   assign bus.clr_done  = clr_done_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: each driven cycle pushes the expected
// post-edge outputs, which a monitor pops and compares just after the edge.
module tb_reg_file_param;
   logic clk;
   logic rstn;

   reg_file_param_if #(.DATA_W(8), .ADDR_W(5)) bus ();

   reg_file_param #(.DATA_W(8), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct packed {
      logic       ready;
      logic       ack;
      logic       done;
      logic       v1;
      logic       v2;
      logic [7:0] d1;
      logic [7:0] d2;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         n_tests = 0;
   int         n_fail  = 0;

   logic [7:0] m_mem [32];
   logic       m_clear;
   logic [4:0] m_idx;
   logic [7:0] m_rd1, m_rd2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [7:0] wd);
      if (a == 5'd0) return 8'h00;
      if (we && wa == a) return wd;
      return m_mem[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
      m_clear = 1'b0;
      m_idx   = 5'd0;
      m_rd1   = 8'h00;
      m_rd2   = 8'h00;
   endtask

   // Drive one cycle of stimulus at the negedge and queue the outputs expected after the edge.
   task automatic step(input logic r1e, input logic [4:0] r1a, input logic r2e,
                       input logic [4:0] r2a, input logic we, input logic [4:0] wa,
                       input logic [7:0] wd, input logic clr);
      exp_t e;
      @(negedge clk);
      bus.rd1_en = r1e; bus.rd1_addr = r1a;
      bus.rd2_en = r2e; bus.rd2_addr = r2a;
      bus.wr_en  = we;  bus.wr_addr  = wa; bus.wr_data = wd;
      bus.clr_req = clr;
      e = '0;
      if (!m_clear) begin
         if (r1e) begin m_rd1 = m_read(r1a, we, wa, wd); e.v1 = 1'b1; end
         if (r2e) begin m_rd2 = m_read(r2a, we, wa, wd); e.v2 = 1'b1; end
         if (we) begin
            e.ack = 1'b1;
            if (wa != 5'd0) m_mem[wa] = wd;
         end
         if (clr) begin m_clear = 1'b1; m_idx = 5'd0; end
      end else begin
         m_mem[m_idx] = 8'h00;
         if (m_idx == 5'd31) begin
            m_clear = 1'b0; m_idx = 5'd0; e.done = 1'b1;
         end else begin
            m_idx = m_idx + 5'd1;
         end
      end
      e.d1 = m_rd1;
      e.d2 = m_rd2;
      e.ready = !m_clear;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00, 1'b0);
   endtask

   always @(posedge clk) begin
      #1;
      if (rstn && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("ready",     {31'd0, bus.ready},     {31'd0, mon_e.ready});
         check("wr_ack",    {31'd0, bus.wr_ack},    {31'd0, mon_e.ack});
         check("clr_done",  {31'd0, bus.clr_done},  {31'd0, mon_e.done});
         check("rd1_valid", {31'd0, bus.rd1_valid}, {31'd0, mon_e.v1});
         check("rd2_valid", {31'd0, bus.rd2_valid}, {31'd0, mon_e.v2});
         check("rd1_data",  {24'd0, bus.rd1_data},  {24'd0, mon_e.d1});
         check("rd2_data",  {24'd0, bus.rd2_data},  {24'd0, mon_e.d2});
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  {31'd0, bus.ready},     32'd1);
      check({tag, "_v1"},     {31'd0, bus.rd1_valid}, 32'd0);
      check({tag, "_v2"},     {31'd0, bus.rd2_valid}, 32'd0);
      check({tag, "_ack"},    {31'd0, bus.wr_ack},    32'd0);
      check({tag, "_done"},   {31'd0, bus.clr_done},  32'd0);
      check({tag, "_d1"},     {24'd0, bus.rd1_data},  32'd0);
      check({tag, "_d2"},     {24'd0, bus.rd2_data},  32'd0);
   endtask

   task automatic read_all();
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 5'(i), 1'b1, 5'(31 - i), 1'b0, 5'd0, 8'h00, 1'b0);
      end
   endtask

   initial begin
      bus.rd1_en = 1'b0; bus.rd1_addr = '0; bus.rd2_en = 1'b0; bus.rd2_addr = '0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.clr_req = 1'b0;
      model_reset();
      rstn = 1'b1;
      #1 rstn = 1'b0;
      #2 check_reset_outputs("reset");
      #9 rstn = 1'b1;

      // Reads after reset, then write followed by read.
      step(1'b1, 5'd3, 1'b1, 5'd31, 1'b0, 5'd0, 8'h00, 1'b0);
      step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 8'hA5, 1'b0);
      step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00, 1'b0);
      // Same-cycle bypass on both ports.
      step(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 8'h3C, 1'b0);
      // Register 0 is hardwired zero, including on the bypass path.
      step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 8'hFF, 1'b0);
      step(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 8'hEE, 1'b0);
      idle();

      // Fill 1..31, reading back the previous address and bypassing the current one.
      for (int i = 1; i < 32; i++) begin
         step(1'b1, 5'(i - 1), 1'b1, 5'(i), 1'b1, 5'(i), 8'(i * 7 + 1), 1'b0);
      end
      step(1'b1, 5'd31, 1'b1, 5'd2, 1'b0, 5'd0, 8'h00, 1'b0);

      // Clear request alongside a write+bypass read; requests during the sweep are ignored.
      step(1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd2, 8'h11, 1'b1);
      for (int i = 0; i < 32; i++) begin
         step(1'($urandom_range(1)), 5'($urandom_range(31)), 1'($urandom_range(1)),
              5'($urandom_range(31)), 1'($urandom_range(1)), 5'($urandom_range(31)),
              8'($urandom_range(255, 1)), 1'($urandom_range(1)));
      end
      read_all();

      // Refill some registers, then reset part-way through a second sweep.
      for (int i = 1; i < 12; i++) begin
         step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(i), 8'(8'h40 + i), 1'b0);
      end
      step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00, 1'b1);
      for (int i = 0; i < 10; i++) idle();
      @(negedge clk);
      #1 rstn = 1'b0;
      #1 check_reset_outputs("midclr");
      exp_q.delete();
      model_reset();
      #1 rstn = 1'b1;
      read_all();
      idle();
      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
